if_id_fifo: RTL and testbench

IF_ID_FIFO -- requirements
Module: if_id_fifo

---
 rtl/if_id_fifo_pkg.sv | 14 +
 rtl/if_id_fifo_mem.sv | 28 ++
 rtl/if_id_fifo.sv | 97 +++++++++
 tb/tb_if_id_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_fifo_pkg.sv
// Shared defines for the IF/ID decoupling buffer.
// Reset/enable levels, zero word and default bus widths.
package if_id_fifo_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        RstDisable   = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    localparam int InstAddrW = 32;
    localparam int InstW     = 32;

endpackage

// File: rtl/if_id_fifo_mem.sv
// Storage array for if_id_fifo: DEPTH x W, one write port, async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module if_id_fifo_mem
    import if_id_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we == WriteEnable) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fifo.sv
// IF->ID instruction buffer: pc/inst FIFO with flush and decode stall.
// Ports: clk, rst (sync, high), flush, if_* (fetch push), id_* (decode pop);
// with IF_ID_FIFO_STATS_EN: occupancy, full_stall_cnt.
module if_id_fifo
    import if_id_fifo_pkg::*;
#(
    parameter int ADDR_W = InstAddrW,
    parameter int INST_W = InstW,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready
`ifdef IF_ID_FIFO_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [31:0]            full_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] rdata;

    // Ready depends on count only, so a full buffer never
    // accepts a push even if decode pops in the same cycle.
    assign if_ready = (count < CNT_W'(DEPTH));
    assign id_valid = (count != '0);

    assign push = if_valid && if_ready && !flush;
    assign pop  = id_valid && id_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case (1'b1)
                (push && !pop): count <= count + 1'b1;
                (pop && !push): count <= count - 1'b1;
                default:        count <= count;
            endcase
        end
    end

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && (rst == RstDisable)),
        .waddr (tail),
        .wdata ({if_pc, if_inst}),
        .raddr (head),
        .rdata (rdata)
    );

    // Outputs forced to zero when empty so stale array data never leaks.
    assign id_pc   = id_valid ? rdata[ENT_W-1:INST_W] : ADDR_W'(ZeroWord);
    assign id_inst = id_valid ? rdata[INST_W-1:0]     : INST_W'(ZeroWord);

`ifdef IF_ID_FIFO_STATS_EN
    assign occupancy = count;

    // Flush does not clear this; it tracks fetch back-pressure overall.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            full_stall_cnt <= '0;
        end else if (if_valid && !if_ready && (full_stall_cnt != '1)) begin
            full_stall_cnt <= full_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed self-checking bench for if_id_fifo (DEPTH=4, 32-bit buses).
// Build with IF_ID_FIFO_STATS_EN to also exercise the stats outputs.
module tb_if_id_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
`ifdef IF_ID_FIFO_STATS_EN
    logic [2:0]  occupancy;
    logic [31:0] full_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    if_id_fifo #(
        .ADDR_W (32),
        .INST_W (32),
        .DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_ready       (if_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_ready       (id_ready)
`ifdef IF_ID_FIFO_STATS_EN
        ,
        .occupancy      (occupancy),
        .full_stall_cnt (full_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
        step();
        if_valid = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".if_ready"}, 64'(if_ready), 64'd1);
        check({tag, ".id_valid"}, 64'(id_valid), 64'd0);
        check({tag, ".id_pc"},    64'(id_pc),    64'd0);
        check({tag, ".id_inst"},  64'(id_inst),  64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = 32'hdead_beef;
        if_inst  = 32'hcafe_f00d;
        id_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_outs("reset");

        // Single push, decode stalled, then consumed.
        push1(32'h100, 32'h0000_0013);
        check("one.valid", 64'(id_valid), 64'd1);
        check("one.pc",    64'(id_pc),    64'h100);
        check("one.inst",  64'(id_inst),  64'h13);
        step();
        step();
        check("stall.pc",   64'(id_pc),   64'h100);
        check("stall.inst", 64'(id_inst), 64'h13);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check("one.popped", 64'(id_valid), 64'd0);
        check("one.zpc",    64'(id_pc),    64'd0);

        // Fill to full (pointers start at 1, so this wraps).
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill.rdy%0d", i), 64'(if_ready), 64'd1);
            push1(32'(4 * i), 32'h1000 + 32'(i));
        end
        check("full.rdy", 64'(if_ready), 64'd0);
        if_valid = 1'b1;
        if_pc    = 32'h10;
        if_inst  = 32'h1010;
        step();
        check("full.rdy2", 64'(if_ready), 64'd0);
        check("full.head", 64'(id_pc),    64'h0);
        // Offer 0x10 while popping: still refused since buffer is full.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain.pc%0d", i),   64'(id_pc),   64'(4 * i));
            check($sformatf("drain.inst%0d", i), 64'(id_inst),
                  64'(32'h1000 + 32'(i)));
            id_ready = 1'b1;
            step();
            if_valid = 1'b0;
        end
        id_ready = 1'b0;
        check("drain.empty", 64'(id_valid), 64'd0);

        // Streaming push+pop: count stays at 1 across wrap.
        push1(32'h300, 32'h3000);
        id_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("stream.pc%0d", k), 64'(id_pc),
                  64'(32'h300 + 32'(4 * (k - 1))));
            if_valid = 1'b1;
            if_pc    = 32'h300 + 32'(4 * k);
            if_inst  = 32'h3000 + 32'(k);
            step();
            check($sformatf("stream.v%0d", k), 64'(id_valid), 64'd1);
            check($sformatf("stream.r%0d", k), 64'(if_ready), 64'd1);
        end
        if_valid = 1'b0;
        check("stream.last", 64'(id_pc), 64'h328);
        step();
        id_ready = 1'b0;
        check("stream.empty", 64'(id_valid), 64'd0);

        // Flush beats a same-cycle push.
        push1(32'h500, 32'h5000);
        push1(32'h504, 32'h5004);
        push1(32'h508, 32'h5008);
        check("preflush.pc", 64'(id_pc), 64'h500);
        flush    = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h200;
        if_inst  = 32'h2000;
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        check("flush.valid", 64'(id_valid), 64'd0);
        check("flush.pc",    64'(id_pc),    64'd0);
        check("flush.rdy",   64'(if_ready), 64'd1);
        step();
        check("flush.no200", 64'(id_valid), 64'd0);

        // Reset beats queued entries and a same-cycle push.
        push1(32'h600, 32'h6000);
        push1(32'h604, 32'h6004);
        rst      = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h608;
        if_inst  = 32'h6008;
        step();
        rst      = 1'b0;
        if_valid = 1'b0;
        check_reset_outs("midrst");
        step();
        check("midrst.hold", 64'(id_valid), 64'd0);

`ifdef IF_ID_FIFO_STATS_EN
        check("stats.clr", 64'(full_stall_cnt), 64'd0);
        for (int i = 0; i < 4; i++) push1(32'h700 + 32'(4 * i), 32'h7000);
        check("stats.nostall", 64'(full_stall_cnt), 64'd0);
        if_valid = 1'b1;
        if_pc    = 32'h710;
        for (int i = 0; i < 5; i++) step();
        if_valid = 1'b0;
        check("stats.cnt",  64'(full_stall_cnt), 64'd5);
        check("stats.occ",  64'(occupancy),      64'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stats.keep", 64'(full_stall_cnt), 64'd5);
        check("stats.occ0", 64'(occupancy),      64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
